// File: rtl/ser_par_pkg.sv
// Shared definitions for the serial/parallel shift unit: mode codes, PISO FSM
// encoding and the bit-order helper used by both shift paths.
package ser_par_pkg;

   localparam logic MODE_SIPO = 1'b0;
   localparam logic MODE_PISO = 1'b1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   // Bit position where a serial bit enters the register; the opposite end is
   // where the next outgoing bit is taken from.
   function automatic int shift_in_pos(input bit msb_first, input int width);
      return msb_first ? 0 : width - 1;
   endfunction

endpackage

// File: rtl/ser_par_bit_counter.sv
// Bit counter shared by the SIPO and PISO paths: sync clear, increment enable,
// wrap at WIDTH-1 and a registered terminal-count flag.
module ser_par_bit_counter #(
   parameter int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt_nxt,
   output logic             tc
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tc_q, tc_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
      end
      tc_d = (cnt_d == CNT_MAX);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         tc_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tc_q  <= tc_d;
      end
   end

   assign cnt_nxt = cnt_d;
   assign tc      = tc_q;

endmodule

// File: rtl/ser_par_shift_unit.sv
// Bidirectional serial/parallel converter: SIPO word assembly (mode 0) and
// PISO serialisation with ready/valid handshake (mode 1). All outputs registered.
//
// state    | meaning
// ST_IDLE  | PISO waiting for a word, par_in_ready=1
// ST_SHIFT | PISO emitting one bit per cycle, WIDTH cycles per word
module ser_par_shift_unit
   import ser_par_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1,
   localparam int CNT_W    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mode,
   input  logic             ser_in,
   input  logic             ser_in_valid,
   output logic [WIDTH-1:0] par_out,
   output logic             par_out_valid,
   input  logic [WIDTH-1:0] par_in,
   input  logic             par_in_valid,
   output logic             par_in_ready,
   output logic             ser_out,
   output logic             ser_out_valid,
   output logic             busy
);

   localparam int IN_POS  = shift_in_pos(MSB_FIRST != 0, WIDTH);
   localparam int OUT_POS = WIDTH - 1 - IN_POS;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic             mode_q;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] par_out_q, par_out_d;
   logic             par_out_valid_q, par_out_valid_d;
   logic             ser_out_q, ser_out_d;
   logic             ser_out_valid_q, ser_out_valid_d;
   logic             par_in_ready_q, par_in_ready_d;
   logic             busy_q, busy_d;

   logic             mode_chg;
   logic             cnt_clr, cnt_inc;
   logic [CNT_W-1:0] cnt_nxt;
   logic             tc;
   logic [WIDTH-1:0] sipo_word, piso_next;

   ser_par_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
      .clk     (clk),
      .reset   (reset),
      .clr     (cnt_clr),
      .inc     (cnt_inc),
      .cnt_nxt (cnt_nxt),
      .tc      (tc)
   );

   assign mode_chg = (mode != mode_q);

   always_comb begin
      sipo_word = '0;
      piso_next = '0;
      if (IN_POS == 0) begin
         sipo_word = {sr_q[WIDTH-2:0], ser_in};
         piso_next = {sr_q[WIDTH-2:0], 1'b0};
      end else begin
         sipo_word = {ser_in, sr_q[WIDTH-1:1]};
         piso_next = {1'b0, sr_q[WIDTH-1:1]};
      end
   end

   always_comb begin
      state_d         = state_q;
      sr_d            = sr_q;
      par_out_d       = par_out_q;
      par_out_valid_d = 1'b0;
      ser_out_d       = ser_out_q;
      ser_out_valid_d = ser_out_valid_q;
      cnt_clr         = 1'b0;
      cnt_inc         = 1'b0;

      if (mode_chg) begin
         // Abort whatever is in flight; the new mode takes over next cycle.
         cnt_clr         = 1'b1;
         state_d         = ST_IDLE;
         ser_out_d       = 1'b0;
         ser_out_valid_d = 1'b0;
      end else if (mode_q == MODE_SIPO) begin
         state_d         = ST_IDLE;
         ser_out_d       = 1'b0;
         ser_out_valid_d = 1'b0;
         if (ser_in_valid) begin
            sr_d    = sipo_word;
            cnt_inc = 1'b1;
            if (tc) begin
               par_out_d       = sipo_word;
               par_out_valid_d = 1'b1;
            end
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               ser_out_d       = 1'b0;
               ser_out_valid_d = 1'b0;
               if (par_in_valid && par_in_ready_q) begin
                  sr_d            = par_in;
                  ser_out_d       = par_in[OUT_POS];
                  ser_out_valid_d = 1'b1;
                  state_d         = ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               cnt_inc = 1'b1;
               if (!tc) begin
                  sr_d            = piso_next;
                  ser_out_d       = piso_next[OUT_POS];
                  ser_out_valid_d = 1'b1;
               end else if (par_in_valid && par_in_ready_q) begin
                  sr_d            = par_in;
                  ser_out_d       = par_in[OUT_POS];
                  ser_out_valid_d = 1'b1;
               end else begin
                  state_d         = ST_IDLE;
                  ser_out_d       = 1'b0;
                  ser_out_valid_d = 1'b0;
               end
            end
            default: begin
               state_d         = ST_IDLE;
               ser_out_d       = 1'b0;
               ser_out_valid_d = 1'b0;
            end
         endcase
      end
   end

   // Ready is registered, so it is computed from the state and count the
   // unit will hold next cycle.
   always_comb begin
      par_in_ready_d = 1'b0;
      busy_d         = 1'b0;
      if (!mode_chg) begin
         if (mode_q == MODE_PISO) begin
            par_in_ready_d = (state_d == ST_IDLE) || (cnt_nxt == CNT_MAX);
            busy_d         = (state_d == ST_SHIFT);
         end else begin
            busy_d = (cnt_nxt != '0);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         mode_q          <= mode;
         sr_q            <= '0;
         par_out_q       <= '0;
         par_out_valid_q <= 1'b0;
         ser_out_q       <= 1'b0;
         ser_out_valid_q <= 1'b0;
         par_in_ready_q  <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         mode_q          <= mode;
         sr_q            <= sr_d;
         par_out_q       <= par_out_d;
         par_out_valid_q <= par_out_valid_d;
         ser_out_q       <= ser_out_d;
         ser_out_valid_q <= ser_out_valid_d;
         par_in_ready_q  <= par_in_ready_d;
         busy_q          <= busy_d;
      end
   end

   assign par_out       = par_out_q;
   assign par_out_valid = par_out_valid_q;
   assign ser_out       = ser_out_q;
   assign ser_out_valid = ser_out_valid_q;
   assign par_in_ready  = par_in_ready_q;
   assign busy          = busy_q;

endmodule

// File: doc/ser_par_shift_unit.md
Name: ser_par_shift_unit

Overview:
- Parametrised bidirectional serial/parallel converter. Next generation of the single-bit DFF register cell, generalised to a WIDTH-bit register with enable, bit counting and framing.
- Mode 0 (SIPO) assembles serial bits into words. Mode 1 (PISO) serialises loaded words with a ready/valid handshake.
- Sits between the serial link pins and the parallel datapath of the serial-parallel converter; targets the same BUF/NOT/NAND/NOR/DFF cell set after synthesis.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = MSB shifted first on both paths; 0 = LSB first.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- mode  in  1  0 = SIPO, 1 = PISO.
- ser_in  in  1  serial data in (SIPO).
- ser_in_valid  in  1  ser_in is sampled this cycle.
- par_out  out  WIDTH  last assembled word (SIPO).
- par_out_valid  out  1  one-cycle pulse: par_out updated.
- par_in  in  WIDTH  word to serialise (PISO).
- par_in_valid  in  1  par_in offered.
- par_in_ready  out  1  converter accepts par_in this cycle.
- ser_out  out  1  serial data out (PISO).
- ser_out_valid  out  1  ser_out carries a live bit.
- busy  out  1  partial word in progress in either mode.

Behaviour:
- Reset is synchronous, active-high, on a single clock (clk). While reset=1 at a clk edge, all state clears:
  - par_out=0, par_out_valid=0, ser_out=0, ser_out_valid=0, par_in_ready=0, busy=0, bit counter=0, FSM=IDLE.
  - par_in_ready rises the first cycle after reset deasserts.
- All outputs are registered; no combinational input-to-output path.
- SIPO (mode=0):
  - Each edge with ser_in_valid=1 shifts ser_in into the shift register and increments the counter.
    - MSB_FIRST=1: shift left, new bit enters at bit 0.
    - MSB_FIRST=0: shift right, new bit enters at bit WIDTH-1.
  - The edge capturing bit WIDTH-1 (counter==WIDTH-1) does three things: loads the completed word into par_out, sets par_out_valid=1 for exactly one cycle, and wraps the counter to 0.
  - Latency: par_out_valid is visible in the cycle after the last bit is sampled.
  - par_out holds its value until the next completed word.
  - Gaps (ser_in_valid=0) freeze the counter and shift register; there is no timeout.
  - busy=1 while counter!=0.
- PISO (mode=1), FSM states IDLE and SHIFT:
  - IDLE: par_in_ready=1. When par_in_valid & par_in_ready, load par_in and go to SHIFT.
  - The first bit appears on ser_out with ser_out_valid=1 in the next cycle.
  - SHIFT: one bit per cycle for exactly WIDTH cycles, in MSB_FIRST order. ser_out_valid stays 1 throughout; busy=1.
  - par_in_ready is 1 during the last SHIFT cycle (counter==WIDTH-1). This allows back-to-back words with no idle bit.
    - Accepted there: stay in SHIFT with the new word.
    - Not accepted: go to IDLE, with ser_out_valid=0 and ser_out=0.
  - par_in_valid while par_in_ready=0 is ignored. The source holds the word until ready.
- Mode change:
  - mode is compared with its registered copy each cycle.
  - Any change aborts the word in progress: counter=0, FSM=IDLE, ser_out_valid=0, no par_out_valid pulse, par_out retains its old value.
  - The new mode becomes effective in the cycle after the change. Bits presented in the change cycle are discarded.
- Inactive-mode inputs are ignored: ser_in_valid in PISO, par_in_valid in SIPO. par_in_ready=0 in SIPO.
- Reset mid-word: the partial word is discarded; no valid pulse is produced for it.
- Counter: CNT_W bits; compares against WIDTH-1 and never exceeds it. Non-power-of-two WIDTH is supported.

Decomposition:
- Shared package ser_par_pkg holds:
  - mode constants MODE_SIPO=1'b0, MODE_PISO=1'b1;
  - FSM state encoding ST_IDLE, ST_SHIFT;
  - a function returning the shift-in position from MSB_FIRST.
- One sub-module, ser_par_bit_counter (parameter WIDTH), shared by both paths. It provides sync clear, increment enable, wrap at WIDTH-1, and a registered terminal-count flag.
- The top level holds the shift register, the FSM and the mode-change detect.

Test Plan:
- Reset/idle: reset=1 for 3 cycles with random inputs → all outputs 0; par_in_ready=1 one cycle after release (mode=1).
- SIPO, WIDTH=8, MSB_FIRST=1: serial bits 1,0,1,0,0,1,0,1 continuous → par_out=8'hA5 and a single par_out_valid pulse one cycle after the 8th bit. Repeat with MSB_FIRST=0 → par_out=8'hA5 from bits 1,0,1,0,0,1,0,1 LSB-first.
- SIPO with gaps: the same bits with ser_in_valid=0 between every bit → the same 8'hA5 result, exactly one pulse; busy=1 from the 1st to the 8th bit.
- PISO back-to-back: par_in=8'h3C, then 8'hC3 offered at the first ready → 16 consecutive ser_out bits 0011110011000011 with ser_out_valid high for 16 cycles and no gap, then IDLE.
- Abort: in SIPO after 5 bits, toggle mode to 1 → no par_out_valid, par_out unchanged, busy=0 next cycle, par_in_ready=1 the cycle after.
- Reset mid-PISO: assert reset at the 4th bit of 8'hFF → ser_out_valid=0 next cycle; no further bits emitted.
